mem_port_arbiter: RTL and testbench

- Shares the single data/instruction memory port of the multicycle core between two requesters: instruction fetch (IF, read-only) and load/store (LS, read/write).
- Sits between the control unit's fetch/load-store paths and the 64-bit memory.
- Sequences each access through a fixed-latency read or single-cycle write.
- Arbitrates simultaneous requests round-robin.

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and load/store.
// Each access is a fixed-latency read or a single-cycle write; ties go round-robin.
module mem_port_arbiter #(
    parameter int AW  = 64,
    parameter int DW  = 64,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_done,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_ls_q, last_ls_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] ls_rdata_q, ls_rdata_d;
    logic          grant_ls;
    logic          capture;

    // owner_q / last_ls_q: 1 = load/store, 0 = fetch
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_ls_d  = last_ls_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        grant_ls   = 1'b0;
        capture    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (if_req || ls_req) begin
                    grant_ls  = ls_req && (!if_req || !last_ls_q);
                    owner_d   = grant_ls;
                    last_ls_d = grant_ls;
                    addr_d    = grant_ls ? ls_addr : if_addr;
                    we_d      = grant_ls && ls_we;
                    wdata_d   = grant_ls ? ls_wdata : '0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_DONE;
                end else if (LAT == 1) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = 3'(LAT - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Read data lands only in the register of the requester that owns the access.
        if (capture) begin
            if (owner_q) begin
                ls_rdata_d = mem_rdata;
            end else begin
                if_rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            last_ls_q  <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_ls_q  <= last_ls_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // Decoded from state so a reset removes write enable and done pulses at once.
    assign mem_we    = (state_q == S_ISSUE) && we_q;
    assign if_done   = (state_q == S_DONE) && !owner_q;
    assign ls_done   = (state_q == S_DONE) && owner_q;
    assign busy      = (state_q != S_IDLE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives three arbiters (LAT = 1, 2, 4) with shared stimulus and checks each
// against a transaction-level model of grant time, completion time and read data.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [63:0] ls_addr = '0;
    logic [63:0] ls_wdata = '0;
    logic [63:0] mem_rdata = '0;

    logic [63:0] if_rdata_w [NI];
    logic [63:0] ls_rdata_w [NI];
    logic [63:0] mem_addr_w [NI];
    logic [63:0] mem_wdata_w [NI];
    logic        if_done_w [NI];
    logic        ls_done_w [NI];
    logic        mem_we_w [NI];
    logic        busy_w [NI];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          we_cnt [NI];
    logic [63:0] rd_log [int];
    bit          use_fixed = 1'b0;
    logic [63:0] fixed_rd = '0;

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // The memory returns a fresh word every cycle; the log lets the model look up
    // exactly what was on mem_rdata during any capture cycle.
    initial begin
        rd_log[0] = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            mem_rdata = use_fixed ? fixed_rd : {$urandom, $urandom};
            rd_log[cyc] = mem_rdata;
        end
    end

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);

        mem_port_arbiter #(.AW(64), .DW(64), .LAT(L)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_w[gi]), .if_done(if_done_w[gi]),
            .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
            .ls_rdata(ls_rdata_w[gi]), .ls_done(ls_done_w[gi]),
            .mem_addr(mem_addr_w[gi]), .mem_wdata(mem_wdata_w[gi]), .mem_we(mem_we_w[gi]),
            .mem_rdata(mem_rdata), .busy(busy_w[gi])
        );

        int          g_c, done_c;
        bit          active, own_ls, we_m, last_ls, idle;
        logic [63:0] exp_if, exp_ls, exp_addr, wdata_m;

        // A transaction granted at cycle g is busy over g+1..done, writes at g+1,
        // and completes at g+2 (store) or g+L+1 (read, data sampled at g+L).
        always @(negedge clk) begin
            if (rst_n) begin
                active = 1'b0; last_ls = 1'b1; g_c = 0; done_c = 0;
                exp_if = '0; exp_ls = '0; exp_addr = '0;
                checkOutput($sformatf("L%0d rst busy", L), 64'(busy_w[gi]), 64'd0);
                checkOutput($sformatf("L%0d rst mem_we", L), 64'(mem_we_w[gi]), 64'd0);
                checkOutput($sformatf("L%0d rst dones", L), 64'({if_done_w[gi], ls_done_w[gi]}), 64'd0);
                checkOutput($sformatf("L%0d rst mem_addr", L), mem_addr_w[gi], 64'd0);
                checkOutput($sformatf("L%0d rst if_rdata", L), if_rdata_w[gi], 64'd0);
                checkOutput($sformatf("L%0d rst ls_rdata", L), ls_rdata_w[gi], 64'd0);
            end else begin
                idle = !active || (cyc > done_c);
                if (active && cyc == done_c && !we_m) begin
                    if (own_ls) exp_ls = rd_log[done_c - 1];
                    else        exp_if = rd_log[done_c - 1];
                end
                checkOutput($sformatf("L%0d busy", L), 64'(busy_w[gi]),
                            64'(active && cyc > g_c && cyc <= done_c));
                checkOutput($sformatf("L%0d if_done", L), 64'(if_done_w[gi]),
                            64'(active && cyc == done_c && !own_ls));
                checkOutput($sformatf("L%0d ls_done", L), 64'(ls_done_w[gi]),
                            64'(active && cyc == done_c && own_ls));
                checkOutput($sformatf("L%0d mem_we", L), 64'(mem_we_w[gi]),
                            64'(active && we_m && cyc == g_c + 1));
                if (active && we_m && cyc == g_c + 1)
                    checkOutput($sformatf("L%0d mem_wdata", L), mem_wdata_w[gi], wdata_m);
                checkOutput($sformatf("L%0d mem_addr", L), mem_addr_w[gi], exp_addr);
                checkOutput($sformatf("L%0d if_rdata", L), if_rdata_w[gi], exp_if);
                checkOutput($sformatf("L%0d ls_rdata", L), ls_rdata_w[gi], exp_ls);
                if (idle) begin
                    active = 1'b0;
                    if (if_req || ls_req) begin
                        if (if_req && ls_req) own_ls = !last_ls;
                        else                  own_ls = ls_req;
                        last_ls  = own_ls;
                        we_m     = own_ls ? ls_we : 1'b0;
                        exp_addr = own_ls ? ls_addr : if_addr;
                        wdata_m  = ls_wdata;
                        g_c      = cyc;
                        done_c   = we_m ? cyc + 2 : cyc + L + 1;
                        active   = 1'b1;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic ireq, input logic lreq, input logic lwe,
                                 input logic [63:0] iaddr, input logic [63:0] laddr,
                                 input logic [63:0] lwdata);
        @(posedge clk);
        #1;
        if_req = ireq; ls_req = lreq; ls_we = lwe;
        if_addr = iaddr; ls_addr = laddr; ls_wdata = lwdata;
    endtask

    // Requests drop and addresses scramble one cycle after the grant; the access
    // must still complete on the latched values.
    task automatic waitDone(input bit want_ls, input int e0, input int e1, input int e2,
                            input string name);
        int seen [NI];
        int expk [NI];
        expk[0] = e0; expk[1] = e1; expk[2] = e2;
        for (int i = 0; i < NI; i++) begin
            seen[i] = -1;
            we_cnt[i] = 0;
        end
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                if_req = 1'b0; ls_req = 1'b0;
                if_addr = {$urandom, $urandom}; ls_addr = {$urandom, $urandom};
                ls_wdata = {$urandom, $urandom};
            end
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if ((want_ls ? ls_done_w[i] : if_done_w[i]) && seen[i] < 0) seen[i] = k;
                if (mem_we_w[i]) we_cnt[i]++;
            end
        end
        for (int i = 0; i < NI; i++)
            checkOutput($sformatf("%s done cycle inst%0d", name, i), 64'(seen[i]), 64'(expk[i]));
    endtask

    task automatic checkAllZero(input string name);
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("%s busy inst%0d", name, i), 64'(busy_w[i]), 64'd0);
            checkOutput($sformatf("%s mem_we inst%0d", name, i), 64'(mem_we_w[i]), 64'd0);
            checkOutput($sformatf("%s dones inst%0d", name, i), 64'({if_done_w[i], ls_done_w[i]}), 64'd0);
            checkOutput($sformatf("%s mem_addr inst%0d", name, i), mem_addr_w[i], 64'd0);
        end
    endtask

    initial begin
        int          ord [4];
        int          nord;
        logic [63:0] saved;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;

        use_fixed = 1'b1;
        fixed_rd = 64'h0000_0000_0050_0093;
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h100, 64'h0, 64'h0);
        waitDone(1'b0, 2, 3, 5, "fetch");
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("fetch if_rdata inst%0d", i), if_rdata_w[i], 64'h0050_0093);
            checkOutput($sformatf("fetch mem_we count inst%0d", i), 64'(we_cnt[i]), 64'd0);
        end
        use_fixed = 1'b0;

        saved = ls_rdata_w[1];
        applyStimulus(1'b0, 1'b1, 1'b1, 64'h0, 64'h2000, 64'hDEAD_BEEF);
        waitDone(1'b1, 2, 2, 2, "store");
        for (int i = 0; i < NI; i++)
            checkOutput($sformatf("store mem_we count inst%0d", i), 64'(we_cnt[i]), 64'd1);
        checkOutput("store ls_rdata kept", ls_rdata_w[1], saved);

        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 64'h3000, 64'h0);
        waitDone(1'b1, 2, 3, 5, "withdraw");

        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1; rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h500, 64'h600, 64'h0);
        nord = 0;
        for (int i = 0; i < 4; i++) ord[i] = 9;
        repeat (40) begin
            @(negedge clk);
            if (nord < 4 && if_done_w[1]) begin ord[nord] = 0; nord++; end
            if (nord < 4 && ls_done_w[1]) begin ord[nord] = 1; nord++; end
        end
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("tie order %0d", i), 64'(ord[i]), 64'(i % 2));
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
        repeat (8) @(posedge clk);

        applyStimulus(1'b1, 1'b0, 1'b0, 64'h700, 64'h0, 64'h0);
        @(posedge clk); #1; if_req = 1'b0;
        @(posedge clk); #3; rst_n = 1'b1;
        #1;
        checkAllZero("async reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h800, 64'h900, 64'h0);
        waitDone(1'b0, 2, 3, 5, "post-reset tie");

        repeat (400) begin
            @(posedge clk);
            #1;
            rst_n    = ($urandom_range(0, 99) == 0);
            if_req   = ($urandom_range(0, 3) != 0);
            ls_req   = ($urandom_range(0, 3) != 0);
            ls_we    = $urandom_range(0, 1) == 1;
            if_addr  = {$urandom, $urandom};
            ls_addr  = {$urandom, $urandom};
            ls_wdata = {$urandom, $urandom};
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
        rst_n = 1'b0;
        repeat (8) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
